// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
// Shared definitions for the tile matching game.
//   - Tile code layout: row[10:9], col[8:7], colour[6:1], flipped[0]
//   - LFSR feedback mask and reset constant used by lfsr16
//   - Deal controller state encoding
//   - Game mode codes and seven-segment hex encodings used by the display
// ---------------------------------------------------------------------------
package tile_pkg;

  // Tile code width and field positions
  localparam int CODE_W    = 11;
  localparam int ROW_MSB   = 10;
  localparam int ROW_LSB   = 9;
  localparam int COL_MSB   = 8;
  localparam int COL_LSB   = 7;
  localparam int COLOR_MSB = 6;
  localparam int COLOR_LSB = 1;
  localparam int FLIP_BIT  = 0;

  // Galois toggle mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam logic [15:0] LFSR_POLY  = 16'hB400;
  localparam logic [15:0] LFSR_RESET = 16'hACE1;

  // Deal controller states
  typedef enum logic [1:0] {
    DEAL_IDLE = 2'd0,
    DEAL_FILL = 2'd1,
    DEAL_SHUF = 2'd2,
    DEAL_DONE = 2'd3
  } deal_state_e;

  // Top-level game modes
  typedef enum logic [1:0] {
    MODE_MENU = 2'd0,
    MODE_PLAY = 2'd1,
    MODE_WIN  = 2'd2,
    MODE_LOSE = 2'd3
  } game_mode_e;

  // Active-low seven-segment encodings for hex digits 0..F
  function automatic logic [6:0] hexSeg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/tile_deal_ctrl_if.sv
// ---------------------------------------------------------------------------
// tile_deal_ctrl_if
// Bundle between the menu/game logic (master) and the deal controller (slave).
//   start       : single-cycle deal request
//   seed_ld     : load seed_i into the LFSR this cycle
//   seed_i      : 16-bit LFSR seed
//   rd_idx      : board read index
//   rd_code     : tile code at rd_idx (combinational, 0 out of range)
//   busy        : deal in progress
//   done        : one-cycle pulse when the board is complete
//   board_valid : board holds a finished deal
// ---------------------------------------------------------------------------
interface tile_deal_ctrl_if #(
  parameter int CODE_W = tile_pkg::CODE_W
);
  logic              start;
  logic              seed_ld;
  logic [15:0]       seed_i;
  logic [3:0]        rd_idx;
  logic [CODE_W-1:0] rd_code;
  logic              busy;
  logic              done;
  logic              board_valid;

  modport master (
    output start, seed_ld, seed_i, rd_idx,
    input  rd_code, busy, done, board_valid
  );

  modport slave (
    input  start, seed_ld, seed_i, rd_idx,
    output rd_code, busy, done, board_valid
  );
endinterface

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1.
//   CLOCK_50 : clock
//   reset    : async active-high reset, loads LFSR_RESET
//   seed_ld  : load seed_i instead of advancing (zero seed maps to LFSR_RESET)
//   seed_i   : seed value
//   q        : current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
  import tile_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        seed_ld,
  input  logic [15:0] seed_i,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic [15:0] w_next;

  // One Galois step: shift right, fold the mask in when a 1 falls out
  always_comb begin
    w_next = {1'b0, r_q[15:1]};
    if (r_q[0]) begin
      w_next = w_next ^ LFSR_POLY;
    end
  end

  // An all-zero state would lock the LFSR, so a zero seed restarts it instead
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_q <= LFSR_RESET;
    end else if (seed_ld) begin
      r_q <= (seed_i == 16'h0000) ? LFSR_RESET : seed_i;
    end else begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/tile_deal_ctrl.sv
// ---------------------------------------------------------------------------
// tile_deal_ctrl
// Deals a board of N_TILES tile codes: fills colour pairs 1..N_TILES/2, then
// shuffles in place with a Fisher-Yates pass driven by lfsr16.
//   CLOCK_50 : clock
//   reset    : async active-high reset (clears board, returns to IDLE)
//   bus      : tile_deal_ctrl_if slave (start/seed in, board read port and
//              status out)
// N_TILES must be even and at most 16.
// ---------------------------------------------------------------------------
module tile_deal_ctrl #(
  parameter int N_TILES = 10,
  parameter int CODE_W  = tile_pkg::CODE_W
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  tile_deal_ctrl_if.slave  bus
);
  import tile_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(N_TILES - 1);

  deal_state_e       r_state;
  deal_state_e       w_nextState;
  logic [CODE_W-1:0] r_board [N_TILES];
  logic [3:0]        r_idx;
  logic              r_boardValid;

  logic [15:0]       w_lfsrQ;
  logic [7:0]        w_unusedLfsrHi;
  logic [7:0]        w_rand;
  logic [4:0]        w_span;
  logic [12:0]       w_product;
  logic [4:0]        w_swapIdx;
  logic [5:0]        w_fillColour;
  logic [CODE_W-1:0] w_fillCode;
  logic [CODE_W-1:0] w_slotI;
  logic [CODE_W-1:0] w_slotJ;
  logic [CODE_W-1:0] w_readCode;
  logic              w_startAccept;

  lfsr16 u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .seed_ld  (bus.seed_ld),
    .seed_i   (bus.seed_i),
    .q        (w_lfsrQ)
  );

  // Only the low byte feeds the shuffle; the upper byte is kept for other users
  assign w_unusedLfsrHi = w_lfsrQ[15:8];
  assign w_rand         = w_lfsrQ[7:0];

  // j = (r * (i+1)) >> 8 scales the random byte into [0, i]
  assign w_span    = {1'b0, r_idx} + 5'd1;
  assign w_product = {5'b0, w_rand} * {8'b0, w_span};
  assign w_swapIdx = w_product[12:8];

  // Slot i (0-based) holds colour (i>>1)+1, so each colour appears twice
  assign w_fillColour = {3'b000, r_idx[3:1]} + 6'd1;

  always_comb begin
    w_fillCode                      = '0;
    w_fillCode[COLOR_MSB:COLOR_LSB] = w_fillColour;
  end

  // Board muxes for the two swap operands and the external read port;
  // an out-of-range rd_idx matches no slot and reads back 0
  always_comb begin
    w_slotI    = '0;
    w_slotJ    = '0;
    w_readCode = '0;
    for (int k = 0; k < N_TILES; k++) begin
      if (4'(k) == r_idx)      w_slotI    = r_board[k];
      if (5'(k) == w_swapIdx)  w_slotJ    = r_board[k];
      if (4'(k) == bus.rd_idx) w_readCode = r_board[k];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state <= DEAL_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // start is only honoured in IDLE; FILL and SHUF run to completion
  always_comb begin
    w_nextState   = r_state;
    w_startAccept = 1'b0;
    unique case (r_state)
      DEAL_IDLE: begin
        if (bus.start) begin
          w_nextState   = DEAL_FILL;
          w_startAccept = 1'b1;
        end
      end
      DEAL_FILL: if (r_idx == LAST_IDX) w_nextState = DEAL_SHUF;
      DEAL_SHUF: if (r_idx == 4'd1)     w_nextState = DEAL_DONE;
      DEAL_DONE: w_nextState = DEAL_IDLE;
      default:   w_nextState = DEAL_IDLE;
    endcase
  end

  // Index counter and board_valid. FILL leaves i at the last slot, which is
  // exactly where the shuffle starts. board_valid is set on the final swap so
  // it rises together with done.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_idx        <= 4'd0;
      r_boardValid <= 1'b0;
    end else begin
      case (r_state)
        DEAL_IDLE: begin
          if (w_startAccept) begin
            r_idx        <= 4'd0;
            r_boardValid <= 1'b0;
          end
        end
        DEAL_FILL: begin
          if (r_idx != LAST_IDX) r_idx <= r_idx + 4'd1;
        end
        DEAL_SHUF: begin
          if (r_idx != 4'd1) begin
            r_idx <= r_idx - 4'd1;
          end else begin
            r_boardValid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Board array. The swap writes both slots in one cycle; when i == j the
  // first branch wins and rewrites slot i with its own value.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_TILES; k++) r_board[k] <= '0;
    end else if (r_state == DEAL_FILL) begin
      for (int k = 0; k < N_TILES; k++) begin
        if (4'(k) == r_idx) r_board[k] <= w_fillCode;
      end
    end else if (r_state == DEAL_SHUF) begin
      for (int k = 0; k < N_TILES; k++) begin
        if (4'(k) == r_idx) begin
          r_board[k] <= w_slotJ;
        end else if (5'(k) == w_swapIdx) begin
          r_board[k] <= w_slotI;
        end
      end
    end
  end

  assign bus.rd_code     = w_readCode;
  assign bus.busy        = (r_state != DEAL_IDLE);
  assign bus.done        = (r_state == DEAL_DONE);
  assign bus.board_valid = r_boardValid;

endmodule

// File: doc/tile_deal_ctrl.md
# tile_deal_ctrl

Board-dealing controller for the tile matching game. On a start request it fills a board of `N_TILES` tile codes with `N_TILES/2` colour pairs, then shuffles them in place with a Fisher–Yates pass driven by a free-running LFSR. The resulting board is exposed to the in-game FSM through a combinational read port. It replaces the fixed `T_0..T_9` constants and sits between the menu/start logic and the in-game tile-flip datapath.

## Interface
- `N_TILES`, default 10: tile count; must be even, ≤ 16.
- `CODE_W`, default 11: tile code width, laid out as row[10:9], col[8:7], colour[6:1], flipped[0].
- `CLOCK_50` in, 1 bit: system clock; all state changes on its rising edge.
- `reset` in, 1 bit: asynchronous, active-high reset.
- `start` in, 1 bit: single-cycle deal request.
- `seed_ld` in, 1 bit: load `seed_i` into the LFSR.
- `seed_i` in, 16 bits: LFSR seed value.
- `rd_idx` in, 4 bits: board read index.
- `rd_code` out, `CODE_W` bits: tile code at `rd_idx`; combinational; 0 when `rd_idx ≥ N_TILES`.
- `busy` out, 1 bit: deal in progress.
- `done` out, 1 bit: one-cycle pulse when the board is complete.
- `board_valid` out, 1 bit: board holds a finished deal.

## Operation
- Board storage: `N_TILES` × `CODE_W` register array.
- Row, col and flipped fields are always written as 0. Only the colour field is dealt.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, reset value 16'hACE1.
  - Advances every cycle in every state, so the seed depends on when the button is pressed.
  - `seed_ld` overrides the advance for that cycle. A seed of 0 loads 16'hACE1 instead.
- States: IDLE, FILL, SHUF, DONE.
- **IDLE**
  - `start` → FILL, with i=0 and `board_valid` cleared.
- **FILL**
  - Each cycle writes slot i with colour = (i>>1)+1.
  - i increments. After slot `N_TILES`-1 → SHUF, with i = `N_TILES`-1.
- **SHUF**
  - Each cycle: r = LFSR[7:0]; j = (r × (i+1)) >> 8, so j ∈ [0,i].
  - Swap slots i and j in the same cycle; i==j leaves the board unchanged.
  - Then i decrements. The step with i=1 is the last → DONE.
- **DONE**
  - One cycle: `done`=1, `board_valid` set, then → IDLE.
- `start` in FILL or SHUF is ignored. `start` in DONE is ignored, since DONE lasts only one cycle.
- `start` in IDLE while `board_valid`=1 re-deals: `board_valid` drops the following cycle.
- `busy` = 1 exactly in FILL, SHUF and DONE.
- Arithmetic:
  - 8×5-bit unsigned multiply giving a 13-bit product; keep bits [12:8].
  - Index counters are 4 bits wide and never wrap.

## Timing
- Reset values:
  - all board slots 0, `rd_code` 0;
  - `busy` 0, `done` 0, `board_valid` 0;
  - state IDLE, LFSR 16'hACE1.
- `start` sampled at edge 0:
  - FILL occupies cycles 1..`N_TILES`.
  - SHUF occupies the next `N_TILES`-1 cycles.
  - DONE follows immediately.
  - For N=10: `done` high in cycle 20; latency 2·`N_TILES` cycles from the start edge.
- `board_valid` rises in the same cycle as `done` and stays high until the next accepted `start` or `reset`.
- `rd_code` has zero latency. Mid-deal contents are undefined for consumers, who must gate reads on `board_valid`.
- `reset` asserted mid-deal clears the board immediately, with no `done` pulse. Dealing resumes only on a new `start`.
- `seed_ld` and `start` in the same cycle: the seed loads, and the first SHUF step uses the LFSR sequence continuing from that seed.

## Structure
- Shared game package `tile_pkg` holds:
  - the tile-code field positions (ROW, COL, COLOR, FLIP);
  - `CODE_W`;
  - the LFSR polynomial and reset constant.
- The mode codes and hex encodings already in the package stay unchanged.
- One sub-module, `lfsr16`, with ports CLOCK_50, reset, seed_ld, seed_i, q[15:0]. It is reused later for other randomised features.
- The FSM, counters and board array stay in `tile_deal_ctrl`.

## Test plan
1. Reset, then `seed_ld` with 16'h1234, then `start`:
   - `busy` rises the next cycle; `done` pulses exactly at cycle 20.
   - Board matches the golden model for seed 16'h1234.
2. Any seed, complete deal:
   - Read `rd_idx` 0..9: colours 1..5 each appear exactly twice.
   - Row, col and flipped are all 0.
   - `rd_idx`=12 gives `rd_code`=0.
3. `start` pulses at cycles 3 and 15 of a deal:
   - Ignored; `done` still at cycle 20, with a single pulse.
4. `reset` at cycle 14 (mid-SHUF):
   - Outputs return to 0 asynchronously; state IDLE; no `done`.
   - A new `start` gives `done` 20 cycles later.
5. Two deals with the same seed give identical boards.
   - Seed 0 behaves identically to seed 16'hACE1.
6. Re-deal from IDLE with `board_valid`=1:
   - `board_valid` is 0 the cycle after `start` and returns to 1 with the new `done`.
